// File: rtl/div_unit.sv
// Restoring shift-subtract 32-bit divider for DIV/DIVU; result_o = {remainder, quotient}.
// Latency: 33 clocks start-to-ready, 1 clock for a zero divisor; one quotient bit per clock.
// No backpressure: start_i is held until the result is consumed, annul_i drops an in-flight op.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BY_ZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        signed_q, signed_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [31:0] dvd_q, dvd_d;     // dividend magnitude; quotient bits shift in at the LSB
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [32:0] diff;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        // Partial remainder stays below the divisor, so a non-negative difference fits in 32 bits.
        diff     = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
        quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? (32'd0 - dvd_q) : dvd_q;
        rem_fix  = (signed_q && sign1_q) ? (32'd0 - rem_q) : rem_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        result_d = result_q;
        ready_d  = ready_q;

        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b0;
                result_d = 64'h0;
                if (start_i && !annul_i) begin
                    signed_d = signed_div_i;
                    sign1_d  = signed_div_i & opdata1_i[31];
                    sign2_d  = signed_div_i & opdata2_i[31];
                    dvd_d    = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
                    dvs_d    = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
                    rem_d    = 32'h0;
                    cnt_d    = 6'd0;
                    state_d  = (opdata2_i == 32'h0) ? ST_BY_ZERO : ST_ON;
                end
            end
            ST_BY_ZERO: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_END;
                    result_d = 64'h0;
                    ready_d  = 1'b1;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = 6'd0;
                end else if (cnt_q != 6'd32) begin
                    if (!diff[32]) begin
                        rem_d = diff[31:0];
                        dvd_d = {dvd_q[30:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[30:0], dvd_q[31]};
                        dvd_d = {dvd_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = 1'b1;
                    state_d  = ST_END;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = 64'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 6'd0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            dvd_q    <= 32'h0;
            dvs_q    <= 32'h0;
            rem_q    <= 32'h0;
            result_q <= 64'h0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes reference results, a negedge monitor pops on ready rise.
// Latency is counted in edges from the edge that samples start_i to the edge that raises ready_o.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          s_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic ready_prev = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d entries pending", sb.size());
        $fatal(1);
    end

    // Reference: plain 64-bit integer division (truncates toward zero, remainder takes dividend sign).
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'h0) return 64'h0;
        la = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        lb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        q  = la / lb;
        r  = la % lb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ready_prev = 1'b0;
            end else begin
                if (ready_o && !ready_prev) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_ready: got result %h, expected no ready (cycle %0d)", result_o, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("result", result_o, e.res);
                        chk("latency", 64'(cyc - e.s_cyc), 64'(e.lat));
                    end
                end
                ready_prev = ready_o;
            end
        end
    end

    // Called at a negedge; drives the request so the next posedge samples it.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t e;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        if (track) begin
            e.res   = ref_div(sgn, a, b);
            e.lat   = (b == 32'h0) ? 1 : 33;
            e.s_cyc = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int          k;
        logic [63:0] exp;
        exp = ref_div(sgn, a, b);
        issue(sgn, a, b, 1'b1);
        @(negedge clk);
        k = 0;
        // Scramble operands while the divide runs; they must not affect the result.
        while (!ready_o && k < 60) begin
            signed_div_i = 1'($urandom);
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            @(negedge clk);
            k++;
        end
        if (!ready_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready_o=0 after %0d cycles, expected 1", k);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end else begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("hold_result", result_o, exp);
            end
            start_i = 1'b0;
            @(negedge clk);
            chk("drop_ready", {63'h0, ready_o}, 64'h0);
            chk("drop_result", result_o, 64'h0);
        end
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a, b;
        int          sel;

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'h0, ready_o}, 64'h0);
        chk("reset_result", result_o, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE);
        run_div(1'b0, 32'hFFFFFFF9, 32'd2);
        run_div(1'b1, 32'h1234, 32'h0);
        run_div(1'b0, 32'h1234, 32'h0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div(1'b0, 32'h80000000, 32'hFFFFFFFF);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1);

        // Annul sampled at edge 10 of 1000/3, then 9/3 starts straight from IDLE.
        issue(1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        chk("annul_ready", {63'h0, ready_o}, 64'h0);
        run_div(1'b0, 32'd9, 32'd3);

        // Reset at edge 20 mid-divide, held with start high to show reset wins.
        @(negedge clk);
        issue(1'b0, 32'd123456, 32'd7, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {63'h0, ready_o}, 64'h0);
        chk("midrst_result", result_o, 64'h0);
        opdata1_i = 32'hDEAD;
        opdata2_i = 32'd3;
        @(negedge clk);
        rst     = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        run_div(1'b0, 32'd50, 32'd5);

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            case (sel)
                0:       b = 32'h0;
                1, 2, 3: b = $urandom_range(1, 15);
                4:       b = 32'hFFFFFFFF;
                5:       begin a = 32'h80000000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_div(sgn, a, b);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
